// File: rtl/gen_toggle_cover_collector.sv
// Toggle-coverage collector: sticky per-point hit bitmap, each first hit streamed once as a global index.
// Hit/count visible 1 cycle after the sampling edge, report 2 cycles; out_ready low holds the report and queues hits in pending.
module gen_toggle_cover_collector #(
   parameter int WIDTH       = 64,
   parameter int MODE        = 2,
   parameter int COVER_INDEX = 0,
   parameter int COVER_TOTAL = 8940,
   localparam int NPOINTS    = (MODE == 2) ? 2 * WIDTH : WIDTH,
   localparam int CW         = $clog2(NPOINTS + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] valid,
   input  logic             clear,
   output logic             out_valid,
   output logic [31:0]      out_index,
   input  logic             out_ready,
   output logic [CW-1:0]    hit_count,
   output logic             all_covered
);

   logic [WIDTH-1:0]   prev_q, prev_d;
   logic               primed_q, primed_d;
   logic [NPOINTS-1:0] hit_q, hit_d;
   logic [NPOINTS-1:0] pending_q, pending_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_index_q, out_index_d;

   logic [NPOINTS-1:0] ev;
   logic [NPOINTS-1:0] new_hits;
   logic [NPOINTS-1:0] sel_mask;
   logic [31:0]        sel;
   logic               any_pending;
   logic               load;

   // Level mode needs no history; edge modes are gated until prev holds a real sample.
   if (MODE == 0) begin : g_level
      assign ev = valid;
   end else if (MODE == 1) begin : g_rise
      assign ev = {WIDTH{primed_q}} & valid & ~prev_q;
   end else begin : g_both
      assign ev = {{WIDTH{primed_q}} & prev_q & ~valid,
                   {WIDTH{primed_q}} & valid & ~prev_q};
   end

   if (COVER_INDEX + NPOINTS > COVER_TOTAL) begin : g_range_err
      $error("gen_toggle_cover_collector: COVER_INDEX + NPOINTS exceeds COVER_TOTAL");
   end

   always_comb begin
      sel         = '0;
      sel_mask    = '0;
      any_pending = 1'b0;
      for (int i = NPOINTS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel         = 32'(i);
            any_pending = 1'b1;
         end
      end
      if (any_pending) sel_mask[sel] = 1'b1;
   end

   always_comb begin
      new_hits    = enable ? (ev & ~hit_q) : '0;
      load        = !out_valid_q || out_ready;

      prev_d      = enable ? valid : prev_q;
      primed_d    = primed_q || enable;
      hit_d       = hit_q | new_hits;
      cnt_d       = cnt_q + CW'($countones(new_hits));
      pending_d   = pending_q | new_hits;
      out_valid_d = out_valid_q;
      out_index_d = out_index_q;

      if (load) begin
         out_valid_d = any_pending;
         if (any_pending) begin
            out_index_d = 32'(COVER_INDEX) + sel;
            pending_d   = (pending_q & ~sel_mask) | new_hits;
         end
      end

      if (clear) begin
         primed_d    = 1'b0;
         hit_d       = '0;
         cnt_d       = '0;
         pending_d   = '0;
         out_valid_d = 1'b0;
         out_index_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_q      <= '0;
         primed_q    <= 1'b0;
         hit_q       <= '0;
         pending_q   <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
      end else begin
         prev_q      <= prev_d;
         primed_q    <= primed_d;
         hit_q       <= hit_d;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_index_q <= out_index_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_index   = out_index_q;
   assign hit_count   = cnt_q;
   assign all_covered = (cnt_q == CW'(NPOINTS));

endmodule

// File: tb/tb_gen_toggle_cover_collector.sv
// Bench for gen_toggle_cover_collector: MODE 2 instance driven through a scoreboard, MODE 0 instance for async reset.
module tb_gen_toggle_cover_collector;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   // MODE 2 instance
   logic        reset2, enable2, clear2, ready2;
   logic [7:0]  valid2;
   logic        out_valid2, all_covered2;
   logic [31:0] out_index2;
   logic [4:0]  hit_count2;

   // MODE 0 instance
   logic        reset0, enable0, clear0, ready0;
   logic [7:0]  valid0;
   logic        out_valid0, all_covered0;
   logic [31:0] out_index0;
   logic [3:0]  hit_count0;

   gen_toggle_cover_collector #(
      .WIDTH(8), .MODE(2), .COVER_INDEX(100), .COVER_TOTAL(8940)
   ) dut2 (
      .clock(clock), .reset(reset2), .enable(enable2), .valid(valid2), .clear(clear2),
      .out_valid(out_valid2), .out_index(out_index2), .out_ready(ready2),
      .hit_count(hit_count2), .all_covered(all_covered2)
   );

   gen_toggle_cover_collector #(
      .WIDTH(8), .MODE(0), .COVER_INDEX(100), .COVER_TOTAL(8940)
   ) dut0 (
      .clock(clock), .reset(reset0), .enable(enable0), .valid(valid0), .clear(clear0),
      .out_valid(out_valid0), .out_index(out_index0), .out_ready(ready0),
      .hit_count(hit_count0), .all_covered(all_covered0)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_idx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input string name, input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
      tick();
      tick();
      chk({name, "_idle"}, 32'(out_valid2), 32'd0);
   endtask

   // Every accepted report must match the next expected index, in order.
   always @(negedge clock) begin
      if (reset2 && !clear2 && out_valid2 && ready2) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL report_unexpected actual=%0d required=none", out_index2);
         end else begin
            exp_idx = exp_q.pop_front();
            if (out_index2 !== exp_idx) begin
               errors++;
               $display("FAIL report_order actual=%0d required=%0d", out_index2, exp_idx);
            end
         end
      end
   end

   logic [7:0] bp_vec [10];

   initial begin
      reset2 = 1'b0; enable2 = 1'b0; clear2 = 1'b0; ready2 = 1'b1; valid2 = 8'h00;
      reset0 = 1'b0; enable0 = 1'b0; clear0 = 1'b0; ready0 = 1'b0; valid0 = 8'h00;
      bp_vec = '{8'h86, 8'h84, 8'h8C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C};

      // Reset state
      repeat (3) tick();
      chk("rst_out_valid", 32'(out_valid2), 32'd0);
      chk("rst_out_index", out_index2, 32'd0);
      chk("rst_hit_count", 32'(hit_count2), 32'd0);
      chk("rst_all_covered", 32'(all_covered2), 32'd0);

      // Prime then single rising edge of bit 0
      reset2 = 1'b1; enable2 = 1'b1; valid2 = 8'h00;
      tick();
      chk("prime_hit_count", 32'(hit_count2), 32'd0);
      valid2 = 8'h01;
      exp_q.push_back(32'd100);
      tick();
      chk("rise0_hit_count", 32'(hit_count2), 32'd1);
      chk("rise0_valid_t1", 32'(out_valid2), 32'd0);
      tick();
      chk("rise0_valid_t2", 32'(out_valid2), 32'd1);
      chk("rise0_index", out_index2, 32'd100);
      tick();
      chk("rise0_drop", 32'(out_valid2), 32'd0);

      // Three simultaneous events drain lowest-first, back to back
      valid2 = 8'h82;
      exp_q.push_back(32'd101);
      exp_q.push_back(32'd107);
      exp_q.push_back(32'd108);
      tick();
      chk("multi_hit_count", 32'(hit_count2), 32'd4);
      tick();
      chk("multi_idx0", out_index2, 32'd101);
      tick();
      chk("multi_idx1", out_index2, 32'd107);
      tick();
      chk("multi_idx2", out_index2, 32'd108);
      tick();
      chk("multi_drop", 32'(out_valid2), 32'd0);

      // Backpressure: first new point (2) is held, later ones (9, 3, 15) queue
      ready2 = 1'b0;
      exp_q.push_back(32'd102);
      exp_q.push_back(32'd103);
      exp_q.push_back(32'd109);
      exp_q.push_back(32'd115);
      for (int i = 0; i < 10; i++) begin
         valid2 = bp_vec[i];
         tick();
         if (i >= 1) begin
            chk("stall_valid", 32'(out_valid2), 32'd1);
            chk("stall_index", out_index2, 32'd102);
         end
      end
      chk("stall_hit_count", 32'(hit_count2), 32'd8);
      ready2 = 1'b1;
      drain("stall_drain", 20);

      // Repeat toggles of an already-covered bit produce nothing
      for (int i = 0; i < 10; i++) begin
         valid2 = valid2 ^ 8'h01;
         tick();
         chk("repeat_quiet", 32'(out_valid2), 32'd0);
      end
      chk("repeat_hit_count", 32'(hit_count2), 32'd8);

      // Full coverage with a stalled report, then clear
      ready2 = 1'b0;
      valid2 = 8'hFF;
      tick();
      valid2 = 8'h00;
      tick();
      chk("full_hit_count", 32'(hit_count2), 32'd16);
      chk("full_all_covered", 32'(all_covered2), 32'd1);
      chk("full_stall_index", out_index2, 32'd104);
      tick();
      chk("full_stall_hold", out_index2, 32'd104);
      clear2 = 1'b1;
      tick();
      clear2 = 1'b0;
      chk("clr_out_valid", 32'(out_valid2), 32'd0);
      chk("clr_out_index", out_index2, 32'd0);
      chk("clr_hit_count", 32'(hit_count2), 32'd0);
      chk("clr_all_covered", 32'(all_covered2), 32'd0);
      ready2 = 1'b1;
      tick();
      chk("clr_prime_quiet", 32'(hit_count2), 32'd0);
      valid2 = 8'h01;
      exp_q.push_back(32'd100);
      tick();
      chk("clr_rise_count", 32'(hit_count2), 32'd1);
      valid2 = 8'h00;
      exp_q.push_back(32'd108);
      tick();
      drain("clr_drain", 10);
      chk("clr_final_count", 32'(hit_count2), 32'd2);

      // MODE 0: level hit with no prime, then async reset mid-report
      reset0 = 1'b1; enable0 = 1'b1; valid0 = 8'h01;
      tick();
      chk("lvl_hit_count", 32'(hit_count0), 32'd1);
      chk("lvl_valid_t1", 32'(out_valid0), 32'd0);
      tick();
      chk("lvl_valid_t2", 32'(out_valid0), 32'd1);
      chk("lvl_index", out_index0, 32'd100);
      tick();
      chk("lvl_hold", out_index0, 32'd100);
      #2;
      reset0 = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid0), 32'd0);
      chk("arst_hit_count", 32'(hit_count0), 32'd0);
      chk("arst_out_index", out_index0, 32'd0);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
